usb_link_arbiter: RTL and testbench

Half-duplex direction controller for the USB transceiver. It shares the single D+/D− pair between the receive path (receiver front end plus RX FSM) and the transmit engine. It enforces bus-turnaround gaps, gives incoming traffic priority over transmit, and times out when an expected response packet never arrives. It sits between the link layer and the PHY, and drives the receiver enable and the line-driver output enable.

---
 rtl/usb_link_arbiter_if.sv | 37 +++
 rtl/usb_link_arbiter.sv | 154 +++++++++++++++
 tb/tb_usb_link_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_link_arbiter_if.sv
// usb_link_arbiter_if
//   Handshake bundle between the link layer / PHY side and the half-duplex
//   direction arbiter.
//   master : the side that drives receive status and transmit requests
//            (link layer, RX FSM, TX engine) and consumes grants/enables.
//   slave  : the arbiter itself.
//   Signals:
//     rx_line_active, rx_frame_complete, rx_error : receive path status
//     tx_req, tx_done, expect_rx                  : transmit engine handshake
//     tx_grant, tx_oe, rx_en, busy                : direction control
//     resp_ok, resp_timeout                       : response qualification pulses
interface usb_link_arbiter_if;
  logic rx_line_active;
  logic rx_frame_complete;
  logic rx_error;
  logic tx_req;
  logic tx_done;
  logic expect_rx;
  logic tx_grant;
  logic tx_oe;
  logic rx_en;
  logic busy;
  logic resp_ok;
  logic resp_timeout;

  modport master (
    output rx_line_active, rx_frame_complete, rx_error,
    output tx_req, tx_done, expect_rx,
    input  tx_grant, tx_oe, rx_en, busy, resp_ok, resp_timeout
  );

  modport slave (
    input  rx_line_active, rx_frame_complete, rx_error,
    input  tx_req, tx_done, expect_rx,
    output tx_grant, tx_oe, rx_en, busy, resp_ok, resp_timeout
  );
endinterface

// File: rtl/usb_link_arbiter.sv
// usb_link_arbiter
//   Half-duplex direction controller sharing the D+/D- pair between the
//   receive path and the transmit engine. Enforces turnaround gaps around
//   every direction change, gives incoming traffic priority over transmit,
//   and times out a missing response after a transmit that expects one.
//   Ports:
//     clk  : system clock, rising edge
//     RST  : synchronous active-high reset
//     bus  : usb_link_arbiter_if.slave (receive status, TX handshake,
//            tx_grant/tx_oe/rx_en/busy, resp_ok/resp_timeout pulses)
module usb_link_arbiter #(
  parameter int TURNAROUND_CYC = 2,
  parameter int RX_TIMEOUT_CYC = 72,
  parameter int CNT_W          = 8
) (
  input logic               clk,
  input logic               RST,
  usb_link_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_GAP, S_TA_TX, S_TX, S_TA_RX, S_WAIT_RESP
  } state_e;

  localparam logic [CNT_W-1:0] TA_LOAD = CNT_W'(TURNAROUND_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(RX_TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_pending_q, resp_pending_d;
  logic             resp_ok_q, resp_ok_d;
  logic             resp_timeout_q, resp_timeout_d;

  logic tx_grant, tx_oe, rx_en, busy;
  logic expired;

  // One shared down-counter: loaded with N-1 on entry to a timed state,
  // the state expires in the cycle it reads zero.
  assign expired = (cnt_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      resp_pending_q <= 1'b0;
      resp_ok_q      <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      resp_pending_q <= resp_pending_d;
      resp_ok_q      <= resp_ok_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  // Next-state, counter and response qualification
  always_comb begin
    state_d        = state_q;
    cnt_d          = expired ? cnt_q : cnt_q - 1'b1;
    resp_pending_d = resp_pending_q;
    resp_ok_d      = 1'b0;
    resp_timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_line_active) begin
          state_d = S_RX;
        end else if (bus.tx_req) begin
          state_d = S_TA_TX;
          cnt_d   = TA_LOAD;
        end
      end
      S_RX: begin
        if (bus.rx_frame_complete || bus.rx_error || !bus.rx_line_active) begin
          state_d = S_GAP;
          cnt_d   = TA_LOAD;
          if (resp_pending_q) begin
            // Error wins over a coincident frame_complete; a line drop
            // without frame_complete is a lost response.
            if (bus.rx_frame_complete && !bus.rx_error) resp_ok_d = 1'b1;
            else                                         resp_timeout_d = 1'b1;
            resp_pending_d = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (bus.rx_line_active) state_d = S_RX;
        else if (expired)       state_d = S_IDLE;
      end
      S_TA_TX: begin
        // Incoming traffic preempts a pending grant.
        if (bus.rx_line_active) state_d = S_RX;
        else if (!bus.tx_req)   state_d = S_IDLE;
        else if (expired)       state_d = S_TX;
      end
      S_TX: begin
        // The engine owns the bus until tx_done; tx_req and line activity
        // are deliberately ignored here.
        if (bus.tx_done) begin
          state_d        = S_TA_RX;
          cnt_d          = TA_LOAD;
          resp_pending_d = bus.expect_rx;
        end
      end
      S_TA_RX: begin
        if (expired) begin
          if (resp_pending_q) begin
            state_d = S_WAIT_RESP;
            cnt_d   = TO_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_RESP: begin
        if (bus.rx_line_active) begin
          state_d = S_RX;
        end else if (expired) begin
          state_d        = S_IDLE;
          resp_timeout_d = 1'b1;
          resp_pending_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs from the state register only
  always_comb begin
    tx_grant = 1'b0;
    tx_oe    = 1'b0;
    rx_en    = 1'b1;
    busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_TX: begin
        tx_grant = 1'b1;
        tx_oe    = 1'b1;
        rx_en    = 1'b0;
      end
      // Neither driving nor listening while the line settles after TX.
      S_TA_RX: rx_en = 1'b0;
      default: ;
    endcase
  end

  assign bus.tx_grant     = tx_grant;
  assign bus.tx_oe        = tx_oe;
  assign bus.rx_en        = rx_en;
  assign bus.busy         = busy;
  assign bus.resp_ok      = resp_ok_q;
  assign bus.resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_usb_link_arbiter.sv
// tb_usb_link_arbiter
//   Directed test-plan scenarios followed by randomized traffic, with every
//   cycle compared against a phase/elapsed-time reference model.
module tb_usb_link_arbiter;
  localparam int TA = 2;
  localparam int TO = 8;

  // Reference model phases
  localparam int P_IDLE = 0, P_RX = 1, P_GAP = 2, P_TATX = 3,
                 P_TX = 4, P_TARX = 5, P_WAIT = 6;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Model state: current phase, cycles already spent in it, pending flag,
  // and the pulses that should be visible this cycle.
  int m_ph  = P_IDLE;
  int m_el  = 0;
  bit m_pend = 0;
  bit m_ok   = 0;
  bit m_to   = 0;

  usb_link_arbiter_if bus();

  usb_link_arbiter #(
    .TURNAROUND_CYC(TA),
    .RX_TIMEOUT_CYC(TO),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0b exp=%0b t=%0t", tag, got, exp, $time);
  endtask

  // Advances the model by one edge using the inputs the DUT samples.
  task automatic model_step();
    int  nph;
    bit  ok;
    bit  to;
    nph = m_ph;
    ok  = 0;
    to  = 0;
    if (rst) begin
      m_ph = P_IDLE; m_el = 0; m_pend = 0; m_ok = 0; m_to = 0;
      return;
    end
    case (m_ph)
      P_IDLE: if (bus.rx_line_active) nph = P_RX;
              else if (bus.tx_req) nph = P_TATX;
      P_RX: if (bus.rx_frame_complete || bus.rx_error || !bus.rx_line_active) begin
        nph = P_GAP;
        if (m_pend) begin
          if (bus.rx_frame_complete && !bus.rx_error) ok = 1;
          else to = 1;
          m_pend = 0;
        end
      end
      P_GAP: if (bus.rx_line_active) nph = P_RX;
             else if (m_el + 1 == TA) nph = P_IDLE;
      P_TATX: if (bus.rx_line_active) nph = P_RX;
              else if (!bus.tx_req) nph = P_IDLE;
              else if (m_el + 1 == TA) nph = P_TX;
      P_TX: if (bus.tx_done) begin
        nph = P_TARX;
        m_pend = bus.expect_rx;
      end
      P_TARX: if (m_el + 1 == TA) nph = m_pend ? P_WAIT : P_IDLE;
      P_WAIT: if (bus.rx_line_active) nph = P_RX;
              else if (m_el + 1 == TO) begin
                nph = P_IDLE; to = 1; m_pend = 0;
              end
      default: nph = P_IDLE;
    endcase
    m_el = (nph == m_ph) ? m_el + 1 : 0;
    m_ph = nph;
    m_ok = ok;
    m_to = to;
  endtask

  // One clock: model follows the edge, outputs compared mid-cycle.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("m_grant", bus.tx_grant, m_ph == P_TX);
    chk("m_oe", bus.tx_oe, m_ph == P_TX);
    chk("m_rx_en", bus.rx_en, !(m_ph == P_TX || m_ph == P_TARX));
    chk("m_busy", bus.busy, m_ph != P_IDLE);
    chk("m_ok", bus.resp_ok, m_ok);
    chk("m_to", bus.resp_timeout, m_to);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_inputs();
    bus.rx_line_active = 0; bus.rx_frame_complete = 0; bus.rx_error = 0;
    bus.tx_req = 0; bus.tx_done = 0; bus.expect_rx = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    run(2);
    chk("rst_rx_en", bus.rx_en, 1);
    chk("rst_oe", bus.tx_oe, 0);
    chk("rst_grant", bus.tx_grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pulses", bus.resp_ok | bus.resp_timeout, 0);
    rst = 0;

    // Plain TX without response
    bus.tx_req = 1;
    run(2);
    chk("ta_no_grant", bus.tx_grant, 0);
    cycle();
    chk("grant_lat3", bus.tx_grant, 1);
    chk("oe_lat3", bus.tx_oe, 1);
    run(7);
    bus.tx_done = 1; bus.expect_rx = 0;
    cycle();
    bus.tx_done = 0; bus.tx_req = 0;
    chk("oe_drop", bus.tx_oe, 0);
    chk("tarx_rx_en", bus.rx_en, 0);
    cycle();
    chk("tarx_busy", bus.busy, 1);
    cycle();
    chk("plain_idle", bus.busy, 0);
    chk("plain_no_to", bus.resp_timeout, 0);

    // Response timeout
    bus.tx_req = 1;
    run(3);
    bus.tx_done = 1; bus.expect_rx = 1;
    cycle();
    bus.tx_done = 0; bus.expect_rx = 0; bus.tx_req = 0;
    run(2);
    chk("wait_rx_en", bus.rx_en, 1);
    run(7);
    chk("to_early", bus.resp_timeout, 0);
    chk("to_wait_busy", bus.busy, 1);
    cycle();
    chk("to_pulse", bus.resp_timeout, 1);
    chk("to_idle", bus.busy, 0);
    cycle();
    chk("to_once", bus.resp_timeout, 0);

    // Response received
    bus.tx_req = 1;
    run(3);
    bus.tx_done = 1; bus.expect_rx = 1;
    cycle();
    bus.tx_done = 0; bus.expect_rx = 0; bus.tx_req = 0;
    run(4);
    bus.rx_line_active = 1;
    run(7);
    bus.rx_frame_complete = 1;
    cycle();
    bus.rx_frame_complete = 0; bus.rx_line_active = 0;
    chk("ok_pulse", bus.resp_ok, 1);
    chk("ok_no_to", bus.resp_timeout, 0);
    cycle();
    chk("ok_once", bus.resp_ok, 0);
    chk("gap_busy", bus.busy, 1);
    cycle();
    chk("ok_idle", bus.busy, 0);

    // Collision: receive preempts a pending grant
    bus.tx_req = 1;
    cycle();
    bus.rx_line_active = 1;
    cycle();
    chk("col_busy", bus.busy, 1);
    chk("col_rx_en", bus.rx_en, 1);
    chk("col_no_grant", bus.tx_grant, 0);
    run(2);
    bus.rx_frame_complete = 1; bus.rx_line_active = 0;
    cycle();
    bus.rx_frame_complete = 0;
    run(4);
    chk("col_grant_early", bus.tx_grant, 0);
    cycle();
    chk("col_grant", bus.tx_grant, 1);

    // Reset while driving
    rst = 1;
    cycle();
    chk("rst_tx_oe", bus.tx_oe, 0);
    chk("rst_tx_grant", bus.tx_grant, 0);
    chk("rst_tx_rx_en", bus.rx_en, 1);
    rst = 0;
    clear_inputs();
    cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (bus.rx_line_active) bus.rx_line_active = ($urandom_range(0, 3) != 0);
      else                    bus.rx_line_active = ($urandom_range(0, 11) == 0);
      bus.rx_frame_complete = ($urandom_range(0, 7) == 0);
      bus.rx_error          = ($urandom_range(0, 19) == 0);
      if (bus.tx_req) bus.tx_req = ($urandom_range(0, 9) != 0);
      else            bus.tx_req = ($urandom_range(0, 6) == 0);
      bus.tx_done   = ($urandom_range(0, 5) == 0);
      bus.expect_rx = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
